// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: synchronises and debounces the three game buttons, keeps the
// committed heading and pause state, and paces the game with a speed-selectable tick.
module snake_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BASE_PERIOD     = 67108864
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] button,
  input  logic [1:0] speed,
  output logic       tick,
  output logic [1:0] dir,
  output logic       turned,
  output logic       paused
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int CW = $clog2(BASE_PERIOD);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]    sync1_r;
  logic [2:0]    sync2_r;
  logic [2:0]    deb_r;
  logic [2:0]    deb_d_r;
  logic [DW-1:0] db_cnt_r [3];

  logic [CW-1:0] tick_cnt_r;
  logic [CW-1:0] period_m1_s;
  logic          tick_r;
  logic          turned_r;
  logic          paused_r;
  logic [1:0]    dir_r;
  logic          pend_vld_r;
  logic [1:0]    pend_dir_r;

  logic [2:0]    press_s;
  logic          wrap_s;
  logic          turn_req_s;
  logic          slot_free_s;
  logic [1:0]    base_dir_s;
  logic [1:0]    prop_dir_s;

  // Two-flop synchroniser followed by a per-button stability counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 3'b111;
      sync2_r <= 3'b111;
      deb_r   <= 3'b111;
      deb_d_r <= 3'b111;
      for (int i = 0; i < 3; i++) begin
        db_cnt_r[i] <= {DW{1'b0}};
      end
    end else begin
      sync1_r <= button;
      sync2_r <= sync1_r;
      deb_d_r <= deb_r;
      for (int i = 0; i < 3; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          db_cnt_r[i] <= {DW{1'b0}};
        end else if (db_cnt_r[i] == DB_LAST) begin
          deb_r[i]    <= sync2_r[i];
          db_cnt_r[i] <= {DW{1'b0}};
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + DW'(1);
        end
      end
    end
  end

  // Tick period minus one for the selected speed
  always_comb begin
    case (speed)
      2'd0:    period_m1_s = CW'(BASE_PERIOD - 1);
      2'd1:    period_m1_s = CW'((BASE_PERIOD >> 1) - 1);
      2'd2:    period_m1_s = CW'((BASE_PERIOD >> 2) - 1);
      2'd3:    period_m1_s = CW'((BASE_PERIOD >> 3) - 1);
      default: period_m1_s = CW'(BASE_PERIOD - 1);
    endcase
  end

  // Press events, wrap detection and the proposed heading for a turn event
  always_comb begin
    press_s     = deb_d_r & ~deb_r;
    wrap_s      = ~paused_r & (tick_cnt_r >= period_m1_s);
    turn_req_s  = press_s[0] ^ press_s[1];
    slot_free_s = wrap_s | ~pend_vld_r;
    // On a wrap the slot refills relative to the heading being committed now.
    if (wrap_s && pend_vld_r) begin
      base_dir_s = pend_dir_r;
    end else begin
      base_dir_s = dir_r;
    end
    if (press_s[0]) begin
      prop_dir_s = base_dir_s - 2'd1;
    end else begin
      prop_dir_s = base_dir_s + 2'd1;
    end
  end

  // Tick counter, tick strobe and heading commit
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_r <= {CW{1'b0}};
      tick_r     <= 1'b0;
      turned_r   <= 1'b0;
      dir_r      <= 2'b11;
    end else begin
      tick_r <= wrap_s;
      if (wrap_s) begin
        tick_cnt_r <= {CW{1'b0}};
        turned_r   <= pend_vld_r;
        if (pend_vld_r) begin
          dir_r <= pend_dir_r;
        end else begin
          dir_r <= dir_r;
        end
      end else begin
        turned_r <= 1'b0;
        if (!paused_r) begin
          tick_cnt_r <= tick_cnt_r + CW'(1);
        end else begin
          tick_cnt_r <= tick_cnt_r;
        end
      end
    end
  end

  // Pending-turn slot and pause toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_r <= 1'b0;
      pend_dir_r <= 2'b00;
      paused_r   <= 1'b0;
    end else begin
      paused_r <= paused_r ^ press_s[2];
      if (turn_req_s && slot_free_s) begin
        pend_vld_r <= 1'b1;
        pend_dir_r <= prop_dir_s;
      end else if (wrap_s) begin
        pend_vld_r <= 1'b0;
      end else begin
        pend_vld_r <= pend_vld_r;
      end
    end
  end

  assign tick   = tick_r;
  assign dir    = dir_r;
  assign turned = turned_r;
  assign paused = paused_r;

endmodule
